bus_outstanding_tracker: RTL and testbench

//  Inline A/D-channel monitor and gate for bus-parametrised TL-UL links, sized from bus_params_pkg.

---
 rtl/bus_params_pkg.sv | 6 +
 rtl/bus_tracker_pkg.sv | 24 ++
 rtl/bus_tracker_lat_cnt.sv | 26 ++
 rtl/bus_outstanding_tracker.sv | 123 ++++++++++++
 tb/tb_bus_outstanding_tracker.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_params_pkg.sv
// Bus-wide field widths shared by link-level helpers.
// Source-ID and transfer-size widths for TL-UL ports.
package bus_params_pkg;
  localparam int BUS_AIW = 5;
  localparam int BUS_SZW = 3;
endpackage

// File: rtl/bus_tracker_pkg.sv
// Types and helpers for bus_outstanding_tracker.
// Entry and error bundles plus the latency width.
package bus_tracker_pkg;
  import bus_params_pkg::*;

  localparam int LatW = 16;

  typedef struct packed {
    logic               pending;
    logic [BUS_SZW-1:0] size;
  } tracker_entry_t;

  typedef struct packed {
    logic unexp;
    logic size;
    logic dup;
  } tracker_err_t;

  function automatic logic [LatW-1:0] sat_inc(
    input logic [LatW-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/bus_tracker_lat_cnt.sv
// One per-source saturating latency counter.
// Zeroed on accept, counts every cycle the source is pending.
module bus_tracker_lat_cnt
  import bus_tracker_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [LatW-1:0] cnt_o
);
  logic [LatW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/bus_outstanding_tracker.sv
// TL-UL A/D outstanding tracker, gate and protocol checker.
// Optional latency tracking: define BUS_TRACKER_LATENCY_EN.
module bus_outstanding_tracker
  import bus_tracker_pkg::*;
#(
  parameter int SrcW   = bus_params_pkg::BUS_AIW,
  parameter int SzW    = bus_params_pkg::BUS_SZW,
  parameter int MaxOut = 16,
  parameter int CntW   = $clog2(MaxOut + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            a_valid_i,
  input  logic [SrcW-1:0] a_source_i,
  input  logic [SzW-1:0]  a_size_i,
  output logic            a_ready_o,
  output logic            a_valid_o,
  input  logic            a_ready_i,
  input  logic            d_valid_i,
  input  logic            d_ready_i,
  input  logic [SrcW-1:0] d_source_i,
  input  logic [SzW-1:0]  d_size_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            full_o,
  output logic            err_unexp_o,
  output logic            err_size_o,
  output logic            err_dup_o,
  output logic            err_sticky_o,
  input  logic            clear_err_i,
  output logic [LatW-1:0] max_latency_o
);
  localparam int NSrc = 2 ** SrcW;

  tracker_entry_t  tbl_q [NSrc];
  tracker_entry_t  tbl_d [NSrc];
  logic [CntW-1:0] cnt_q, cnt_d;
  tracker_err_t    err_q, err_d;
  logic            sticky_q, sticky_d;
  logic            block, acc, ret, hit;

  // Gate depends only on registered state: no D-to-A path.
  assign full_o    = (cnt_q == CntW'(MaxOut));
  assign block     = full_o | tbl_q[a_source_i].pending;
  assign a_valid_o = a_valid_i & ~block;
  assign a_ready_o = a_ready_i & ~block;

  assign acc = a_valid_o & a_ready_i;
  assign ret = d_valid_i & d_ready_i;
  assign hit = ret & tbl_q[d_source_i].pending;

  always_comb begin
    tbl_d = tbl_q;
    if (acc) begin
      tbl_d[a_source_i].pending = 1'b1;
      tbl_d[a_source_i].size    = a_size_i;
    end
    if (hit) tbl_d[d_source_i].pending = 1'b0;

    cnt_d = cnt_q;
    unique case ({acc, hit})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_d.unexp = ret & ~tbl_q[d_source_i].pending;
    err_d.size  = hit & (tbl_q[d_source_i].size != d_size_i);
    err_d.dup   = a_valid_i & tbl_q[a_source_i].pending;
    sticky_d    = (|err_d) | (sticky_q & ~clear_err_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSrc; i++) tbl_q[i] <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      tbl_q    <= tbl_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_unexp_o   = err_q.unexp;
  assign err_size_o    = err_q.size;
  assign err_dup_o     = err_q.dup;
  assign err_sticky_o  = sticky_q;

`ifdef BUS_TRACKER_LATENCY_EN
  logic [LatW-1:0] lat [NSrc];
  logic [LatW-1:0] lat_ret, max_lat_q, max_lat_d;

  for (genvar g = 0; g < NSrc; g++) begin : g_lat
    bus_tracker_lat_cnt u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (acc && (a_source_i == SrcW'(g))),
      .inc_i  (tbl_q[g].pending),
      .cnt_o  (lat[g])
    );
  end

  // Counter lags one cycle behind the accept, hence the +1.
  assign lat_ret = sat_inc(lat[d_source_i]);

  always_comb begin
    max_lat_d = clear_err_i ? '0 : max_lat_q;
    if (hit && (lat_ret > max_lat_d)) max_lat_d = lat_ret;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) max_lat_q <= '0;
    else max_lat_q <= max_lat_d;
  end

  assign max_latency_o = max_lat_q;
`else
  assign max_latency_o = '0;
`endif
endmodule

// File: tb/tb_bus_outstanding_tracker.sv
// Scoreboard bench for bus_outstanding_tracker.
// Directed scenarios followed by constrained-random traffic.
module tb_bus_outstanding_tracker;
  localparam int SRCW   = 5;
  localparam int SZW    = 3;
  localparam int NSRC   = 32;
  localparam int MAXOUT = 16;
  localparam int CNTW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_valid = 1'b0;
  logic [SRCW-1:0] a_source = '0;
  logic [SZW-1:0]  a_size = '0;
  logic            a_ready_in = 1'b0;
  logic            d_valid = 1'b0;
  logic            d_ready = 1'b0;
  logic [SRCW-1:0] d_source = '0;
  logic [SZW-1:0]  d_size = '0;
  logic            clear_err = 1'b0;
  logic            a_ready_o, a_valid_o, full_o;
  logic            err_unexp_o, err_size_o, err_dup_o, err_sticky_o;
  logic [CNTW-1:0] outstanding_o;
  logic [15:0]     max_latency_o;

  bus_outstanding_tracker dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .a_valid_i     (a_valid),
    .a_source_i    (a_source),
    .a_size_i      (a_size),
    .a_ready_o     (a_ready_o),
    .a_valid_o     (a_valid_o),
    .a_ready_i     (a_ready_in),
    .d_valid_i     (d_valid),
    .d_ready_i     (d_ready),
    .d_source_i    (d_source),
    .d_size_i      (d_size),
    .outstanding_o (outstanding_o),
    .full_o        (full_o),
    .err_unexp_o   (err_unexp_o),
    .err_size_o    (err_size_o),
    .err_dup_o     (err_dup_o),
    .err_sticky_o  (err_sticky_o),
    .clear_err_i   (clear_err),
    .max_latency_o (max_latency_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    bit ardy, avld, full, unexp, sz, dup, sticky;
    int outst, maxlat, cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;

  // Reference model: set of in-flight sources with size and issue cycle.
  bit m_pend[NSRC];
  int m_size[NSRC];
  int m_acc_cyc[NSRC];
  bit m_unexp, m_sz, m_dup, m_sticky;
  int m_maxlat;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NSRC; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic check(input string nm, input int act, input int exp, input int cyc);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic op(input bit av = 0, input int asrc = 0, input int asz = 0,
                    input bit dv = 0, input int dsrc = 0, input int dsz = 0,
                    input bit clr = 0, input bit rst = 1, input bit ardy = 1,
                    input bit drdy = 1, input bit chk = 1);
    exp_t e;
    int   cnt, base, lat;
    bit   blk, acc, ret, hit;
    @(posedge clk);
    #1;
    rst_n = rst; a_valid = av; a_source = SRCW'(asrc); a_size = SZW'(asz);
    a_ready_in = ardy; d_valid = dv; d_ready = drdy;
    d_source = SRCW'(dsrc); d_size = SZW'(dsz); clear_err = clr;
    cnt = m_count();
    blk = (cnt == MAXOUT) || m_pend[asrc];
    e.chk = chk; e.cyc = ncyc;
    e.ardy = ardy && !blk; e.avld = av && !blk;
    e.outst = cnt; e.full = (cnt == MAXOUT);
    e.unexp = m_unexp; e.sz = m_sz; e.dup = m_dup;
    e.sticky = m_sticky; e.maxlat = m_maxlat;
    sbq.push_back(e);
    if (!rst) begin
      for (int i = 0; i < NSRC; i++) m_pend[i] = 0;
      m_unexp = 0; m_sz = 0; m_dup = 0; m_sticky = 0; m_maxlat = 0;
    end else begin
      acc = av && !blk && ardy;
      ret = dv && drdy;
      hit = ret && m_pend[dsrc];
      m_unexp = ret && !m_pend[dsrc];
      m_sz = hit && (m_size[dsrc] != dsz);
      m_dup = av && m_pend[asrc];
`ifdef BUS_TRACKER_LATENCY_EN
      base = clr ? 0 : m_maxlat;
      if (hit) begin
        lat = ncyc - m_acc_cyc[dsrc];
        if (lat > 65535) lat = 65535;
        if (lat > base) base = lat;
      end
      m_maxlat = base;
`else
      base = 0; lat = 0;
      m_maxlat = base + lat;
`endif
      if (hit) m_pend[dsrc] = 0;
      if (acc) begin
        m_pend[asrc] = 1; m_size[asrc] = asz; m_acc_cyc[asrc] = ncyc;
      end
      m_sticky = m_unexp || m_sz || m_dup || (m_sticky && !clr);
    end
    ncyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          check("a_ready_o", a_ready_o, e.ardy, e.cyc);
          check("a_valid_o", a_valid_o, e.avld, e.cyc);
          check("outstanding_o", outstanding_o, e.outst, e.cyc);
          check("full_o", full_o, e.full, e.cyc);
          check("err_unexp_o", err_unexp_o, e.unexp, e.cyc);
          check("err_size_o", err_size_o, e.sz, e.cyc);
          check("err_dup_o", err_dup_o, e.dup, e.cyc);
          check("err_sticky_o", err_sticky_o, e.sticky, e.cyc);
          check("max_latency_o", max_latency_o, e.maxlat, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    int plist[$];
    int s, wait_n;
    op(.rst(0), .chk(0));
    op(.rst(0));
    op();
    // basic accept / retire
    op(.av(1), .asrc(3), .asz(2));
    op();
    op(.dv(1), .dsrc(3), .dsz(2));
    op(); op();
    // fill to MaxOut, 17th stalls, retire frees it next cycle
    for (int i = 0; i < MAXOUT; i++) op(.av(1), .asrc(i + 16), .asz(1));
    op(.av(1), .asrc(0), .asz(1));
    op(.av(1), .asrc(0), .asz(1), .dv(1), .dsrc(16), .dsz(1));
    op(.av(1), .asrc(0), .asz(1));
    op();
    for (int i = 17; i < 32; i++) op(.dv(1), .dsrc(i), .dsz(1));
    op(.dv(1), .dsrc(0), .dsz(1));
    op();
    // duplicate source stalls
    op(.av(1), .asrc(5), .asz(3));
    for (int i = 0; i < 3; i++) op(.av(1), .asrc(5), .asz(3));
    op(.av(1), .asrc(5), .asz(3), .dv(1), .dsrc(5), .dsz(3));
    op(.av(1), .asrc(5), .asz(3));
    op(.dv(1), .dsrc(5), .dsz(3));
    op(); op();
    op(.clr(1));
    // unexpected response, then clear sticky
    op(.dv(1), .dsrc(9), .dsz(0));
    op(); op(.clr(1)); op();
    // size mismatch
    op(.av(1), .asrc(1), .asz(2));
    op(.dv(1), .dsrc(1), .dsz(0));
    op(); op();
    // same-cycle accept and retire of different sources
    op(.av(1), .asrc(4), .asz(1));
    op(.av(1), .asrc(2), .asz(1), .dv(1), .dsrc(4), .dsz(1));
    op(.dv(1), .dsrc(2), .dsz(1));
    op(.clr(1));
    // latency of 7 cycles
    op(.av(1), .asrc(0), .asz(0));
    for (int i = 0; i < 6; i++) op();
    op(.dv(1), .dsrc(0), .dsz(0));
    op(); op();
    // reset mid-flight discards state
    op(.av(1), .asrc(6)); op(.av(1), .asrc(7));
    op(.av(1), .asrc(8)); op(.av(1), .asrc(10));
    op(.rst(0));
    op(.dv(1), .dsrc(6), .dsz(0));
    op(); op();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      plist.delete();
      for (int i = 0; i < NSRC; i++) if (m_pend[i]) plist.push_back(i);
      if (plist.size() > 0 && $urandom_range(7) != 0)
        s = plist[$urandom_range(plist.size() - 1)];
      else
        s = $urandom_range(NSRC - 1);
      op(.av($urandom_range(3) != 0), .asrc($urandom_range(NSRC - 1)),
         .asz($urandom_range(7)), .ardy($urandom_range(3) != 0),
         .dv($urandom_range(2) == 0), .dsrc(s),
         .dsz(($urandom_range(7) == 0) ? $urandom_range(7) : m_size[s]),
         .drdy($urandom_range(3) != 0), .clr($urandom_range(49) == 0),
         .rst($urandom_range(499) != 0));
    end
    wait_n = 0;
    while (sbq.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    if (sbq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
